// File: rtl/flow_sram_client.sv
// flow_sram_client: single-outstanding command client for a req/ack SRAM port.
// A command (write or read) is accepted in IDLE, turned into a registered SRAM
// request that holds until acknowledged, and a read then waits for the data
// strobe (or a timeout) before presenting one response to the consumer.
module flow_sram_client #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 72,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  wr_done,
  // SRAM write port
  output logic [ADDR_WIDTH-1:0] wr_0_addr,
  output logic [DATA_WIDTH-1:0] wr_0_data,
  output logic                  wr_0_req,
  input  logic                  wr_0_ack,
  // SRAM read port
  output logic [ADDR_WIDTH-1:0] rd_0_addr,
  output logic                  rd_0_req,
  input  logic                  rd_0_ack,
  input  logic [DATA_WIDTH-1:0] rd_0_data,
  input  logic                  rd_0_vld,
  // diagnostics
  output logic                  late_vld
);

  // The ack cycle counts as the first cycle of the read wait, so the wait
  // counter (cleared on entry to RD_WAIT) ends the wait at TIMEOUT-2 and the
  // timeout response appears exactly TIMEOUT cycles after the ack cycle.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RSP     = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             wr_fire;
  logic             rd_hit;
  logic             rd_tmo;
  logic [CNT_W-1:0] wait_cnt;

  // Handshake-facing status comes straight from the state register.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);

  // Next-state decode; acks and strobes only matter in their own state.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    wr_fire    = 1'b0;
    rd_hit     = 1'b0;
    rd_tmo     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (wr_0_ack) begin
          wr_fire    = 1'b1;
          state_next = IDLE;
        end
      end
      RD_REQ: begin
        if (rd_0_ack) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_0_vld) begin
          rd_hit     = 1'b1;
          state_next = RSP;
        end else if (wait_cnt == CNT_LAST) begin
          rd_tmo     = 1'b1;
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered SRAM request strobes track the upcoming state, so they can
  // never overlap and drop the cycle after the ack; wr_done marks that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_0_req <= 1'b0;
      rd_0_req <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      wr_0_req <= (state_next == WR_REQ);
      rd_0_req <= (state_next == RD_REQ);
      wr_done  <= wr_fire;
    end
  end

  // Command latch: address/data are captured once at acceptance and held
  // steady on the SRAM port for the whole request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_0_addr <= '0;
      wr_0_data <= '0;
      rd_0_addr <= '0;
    end else if (accept) begin
      if (cmd_write) begin
        wr_0_addr <= cmd_addr;
        wr_0_data <= cmd_wdata;
      end else begin
        rd_0_addr <= cmd_addr;
      end
    end
  end

  // Read wait counter: runs only in RD_WAIT, zero everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == RD_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Response capture: real data on the strobe, zero plus error on timeout;
  // held unchanged while the response waits for rsp_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (rd_hit) begin
      rsp_data <= rd_0_data;
      rsp_err  <= 1'b0;
    end else if (rd_tmo) begin
      rsp_data <= '0;
      rsp_err  <= 1'b1;
    end
  end

  // Sticky flag for a data strobe that arrives with no read outstanding
  // (including the ack cycle itself and any strobe after an abandoned read).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      late_vld <= 1'b0;
    end else if (rd_0_vld && (state != RD_WAIT)) begin
      late_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flow_sram_client.sv
// Bench for flow_sram_client: fake SRAM model plus response scoreboard.
module tb_flow_sram_client;

  localparam int AW  = 19;
  localparam int DW  = 72;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, wr_done;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] wr_0_addr, rd_0_addr;
  logic [DW-1:0] wr_0_data;
  logic          wr_0_req, wr_0_ack, rd_0_req, rd_0_ack;
  logic [DW-1:0] rd_0_data = '0;
  logic          rd_0_vld  = 1'b0;
  logic          late_vld;

  always #5 clk = ~clk;

  flow_sram_client #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .wr_done(wr_done),
    .wr_0_addr(wr_0_addr), .wr_0_data(wr_0_data), .wr_0_req(wr_0_req),
    .wr_0_ack(wr_0_ack),
    .rd_0_addr(rd_0_addr), .rd_0_req(rd_0_req), .rd_0_ack(rd_0_ack),
    .rd_0_data(rd_0_data), .rd_0_vld(rd_0_vld),
    .late_vld(late_vld)
  );

  // ---------------- fake SRAM (driven on the falling edge) ----------------
  int            ack_delay  = 0;   // main-controlled knobs
  int            vld_delay  = 1;
  bit            phased     = 1'b0;
  bit            vld_en     = 1'b1;
  int            inject_req = 0;
  int            inject_seen = 0;  // model-private state
  int            wr_n = 0, rd_n = 0, pwait = 0;
  bit            pend = 1'b0;
  logic [2:0]    ph = 3'd0;
  logic          wr_ok = 1'b0, rd_ok = 1'b0;
  logic [DW-1:0] pdata = '0;
  logic [DW-1:0] mem [logic [AW-1:0]];

  assign wr_0_ack = wr_0_req & wr_ok;
  assign rd_0_ack = rd_0_req & rd_ok;

  // SRAM behaviour: ack after ack_delay cycles (or on counter phase), one data
  // strobe per accepted read after vld_delay cycles (or on counter phase).
  always @(negedge clk) begin
    ph = ph + 3'd1;
    wr_n = wr_0_req ? wr_n + 1 : 0;
    rd_n = rd_0_req ? rd_n + 1 : 0;
    wr_ok = phased ? (ph[1:0] == 2'd0) : (wr_n > ack_delay);
    rd_ok = phased ? (ph[1:0] == 2'd2) : (rd_n > ack_delay);
    rd_0_vld = 1'b0;
    if (inject_req != inject_seen) begin
      inject_seen = inject_req;
      rd_0_vld = 1'b1;
      rd_0_data = 72'hDEAD_BEEF;
    end else if (pend) begin
      pwait++;
      if (phased ? ph[0] : (pwait >= vld_delay)) begin
        rd_0_vld = 1'b1;
        rd_0_data = pdata;
        pend = 1'b0;
      end
    end
    if (wr_0_req && wr_ok) mem[wr_0_addr] = wr_0_data;
    if (rd_0_req && rd_ok && vld_en) begin
      pend = 1'b1;
      pwait = 0;
      pdata = mem.exists(rd_0_addr) ? mem[rd_0_addr] : '0;
    end
  end

  // ---------------- scoreboard and checking ----------------
  int            errors = 0;
  int            checks = 0;
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] exp_mem [logic [AW-1:0]];

  task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [DW:0] e;
    check("req_excl", 73'(wr_0_req & rd_0_req), 73'(0));
    check("rdy_busy", 73'(cmd_ready & (wr_0_req | rd_0_req | rsp_valid)), 73'(0));
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexp", 73'(1), 73'(0));
      end else begin
        e = exp_q.pop_front();
        check("rsp", {rsp_err, rsp_data}, e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // mode 0: normal, 1: expect timeout response, 2: abandoned (no response)
  task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int mode);
    int n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (!cmd_ready) check("send_wait", 73'(0), 73'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    if (wr) exp_mem[a] = d;
    else if (mode == 0) exp_q.push_back({1'b0, exp_mem.exists(a) ? exp_mem[a] : {DW{1'b0}}});
    else if (mode == 1) exp_q.push_back({1'b1, {DW{1'b0}}});
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    check("drain", 73'(exp_q.size()), 73'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 73'(cmd_ready), 73'(1));
    check({tag, "_rsp_valid"}, 73'(rsp_valid), 73'(0));
    check({tag, "_rsp_err"},   73'(rsp_err), 73'(0));
    check({tag, "_rsp_data"},  73'(rsp_data), 73'(0));
    check({tag, "_wr_done"},   73'(wr_done), 73'(0));
    check({tag, "_wr_req"},    73'(wr_0_req), 73'(0));
    check({tag, "_rd_req"},    73'(rd_0_req), 73'(0));
    check({tag, "_wr_addr"},   73'(wr_0_addr), 73'(0));
    check({tag, "_wr_data"},   73'(wr_0_data), 73'(0));
    check({tag, "_rd_addr"},   73'(rd_0_addr), 73'(0));
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int n;
    logic [95:0]   r;
    bit            w;
    logic [AW-1:0] a;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_vals("por");
    check("por_late", 73'(late_vld), 73'(0));

    // write with ack delayed three cycles
    ack_delay = 3;
    send(1'b1, 19'h00010, 72'h0A5, 0);
    n = 0;
    while (wr_0_req && n < 20) begin
      check("wr_addr", 73'(wr_0_addr), 73'(19'h00010));
      check("wr_data", 73'(wr_0_data), 73'(72'h0A5));
      check("wr_no_rd", 73'(rd_0_req), 73'(0));
      check("wr_done_early", 73'(wr_done), 73'(0));
      n++;
      tick();
    end
    check("wr_req_cycles", 73'(n), 73'(4));
    check("wr_done_pulse", 73'(wr_done), 73'(1));
    tick();
    check("wr_done_single", 73'(wr_done), 73'(0));

    // read back with data three cycles after ack, consumer stalled
    ack_delay = 0; vld_delay = 3; rsp_ready = 1'b0;
    send(1'b0, 19'h00010, '0, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check("rd_latency", 73'(n), 73'(4));
    check("rd_data", 73'(rsp_data), 73'(72'h0A5));
    check("rd_err", 73'(rsp_err), 73'(0));
    repeat (5) begin
      tick();
      check("hold_valid", 73'(rsp_valid), 73'(1));
      check("hold_data", 73'(rsp_data), 73'(72'h0A5));
      check("hold_err", 73'(rsp_err), 73'(0));
      check("hold_ready", 73'(cmd_ready), 73'(0));
    end
    rsp_ready = 1'b1;
    tick();
    check("rsp_taken", 73'(rsp_valid), 73'(0));
    check("ready_back", 73'(cmd_ready), 73'(1));
    check("late_clean", 73'(late_vld), 73'(0));

    // read timeout, then a stray strobe
    vld_en = 1'b0;
    send(1'b0, 19'h00020, '0, 1);
    n = 0;
    while (!rsp_valid && n < 200) begin tick(); n++; end
    check("tmo_latency", 73'(n), 73'(TMO));
    check("tmo_err", 73'(rsp_err), 73'(1));
    check("tmo_data", 73'(rsp_data), 73'(0));
    repeat (2) tick();
    inject_req++;
    repeat (3) begin
      tick();
      check("no_2nd_rsp", 73'(rsp_valid), 73'(0));
    end
    check("late_set", 73'(late_vld), 73'(1));
    vld_en = 1'b1; vld_delay = 1;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    check("late_cleared", 73'(late_vld), 73'(0));

    // back-to-back write then read with cmd_valid held, immediate ack
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 19'h00030; cmd_wdata = 72'h12_3456_789A_BCDE_F012;
    exp_mem[19'h00030] = 72'h12_3456_789A_BCDE_F012;
    n = 0;
    while (!wr_0_req && n < 20) begin tick(); n++; end
    check("b2b_wr_seen", 73'(wr_0_req), 73'(1));
    cmd_write = 1'b0;
    exp_q.push_back({1'b0, 72'h12_3456_789A_BCDE_F012});
    n = 0;
    while (!rd_0_req && n < 20) begin tick(); n++; end
    check("b2b_rd_seen", 73'(rd_0_req), 73'(1));
    cmd_valid = 1'b0;
    drain();

    // reset while waiting for read data; the data arrives after release
    vld_delay = 6;
    send(1'b0, 19'h00030, '0, 2);
    tick();
    reset = 1'b1;
    #1;
    check("arst_ready", 73'(cmd_ready), 73'(1));
    check("arst_rd_req", 73'(rd_0_req), 73'(0));
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) begin
      tick();
      check("rst_no_rsp", 73'(rsp_valid), 73'(0));
    end
    check_reset_vals("mid");
    check("mid_late", 73'(late_vld), 73'(1));
    reset = 1'b1; tick(); reset = 1'b0; tick();

    // random traffic against the phase-gated SRAM model
    phased = 1'b1; vld_en = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 15));
      r = {$urandom(), $urandom(), $urandom()};
      send(w, a, r[DW-1:0], 0);
      if (w) begin
        n = 0;
        while (!wr_done && n < 50) begin tick(); n++; end
        if (!wr_done) check("rnd_wr_wait", 73'(0), 73'(1));
      end else begin
        drain();
      end
    end
    check("rnd_late", 73'(late_vld), 73'(0));
    check("rnd_q_empty", 73'(exp_q.size()), 73'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
